// File: rtl/aes_req_arbiter.sv
// Round-robin front end that shares one AES-256 encrypt core among NUM_REQ requesters.
// Define AES_ARB_WATCHDOG_EN to compile in the WAIT_CORE timeout (TIMEOUT_CYCLES) and the rsp_err abort path.
module aes_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*128-1:0] req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   core_start,
  output logic [127:0]           core_data,
  input  logic                   core_valid,
  input  logic [127:0]           core_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [127:0]           rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_err,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CORE, RESP} state_t;

  state_t          state_reg, state_next;
  logic [ID_W-1:0] last_grant_reg;
  logic [ID_W-1:0] id_reg;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand_idx;
  logic            grant_valid;
  logic            core_start_reg;
  logic [127:0]    core_data_reg;
  logic [127:0]    rsp_data_reg;
  logic            timeout;
  logic [127:0]    req_blk [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_blk
      assign req_blk[gi] = req_data[128*gi +: 128];
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest one after last_grant wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand_idx = ID_W'((int'(last_grant_reg) + off) % NUM_REQ);
      if (req_valid[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          req_ready[grant_idx] = 1'b1;
          state_next           = ISSUE;
        end
      end
      ISSUE:     state_next = WAIT_CORE;
      WAIT_CORE: if (core_valid || timeout) state_next = RESP;
      RESP:      if (rsp_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= ID_W'(NUM_REQ - 1);
      id_reg         <= '0;
      core_start_reg <= 1'b0;
      core_data_reg  <= '0;
      rsp_data_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      core_start_reg <= (state_reg == IDLE) && grant_valid;
      if ((state_reg == IDLE) && grant_valid) begin
        core_data_reg  <= req_blk[grant_idx];
        id_reg         <= grant_idx;
        last_grant_reg <= grant_idx;
      end
      // A real result takes priority over a timeout landing in the same cycle.
      if (state_reg == WAIT_CORE) begin
        if (core_valid)   rsp_data_reg <= core_result;
        else if (timeout) rsp_data_reg <= '0;
      end
    end
  end

`ifdef AES_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            rsp_err_reg;

  // Counter equals the number of WAIT_CORE cycles already spent, so RESP starts TIMEOUT_CYCLES after entry.
  assign timeout = (state_reg == WAIT_CORE) && (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_reg  <= '0;
      rsp_err_reg <= 1'b0;
    end else begin
      if (state_reg == ISSUE)
        wd_cnt_reg <= '0;
      else if ((state_reg == WAIT_CORE) && !timeout)
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      if (state_reg == WAIT_CORE) begin
        if (core_valid)   rsp_err_reg <= 1'b0;
        else if (timeout) rsp_err_reg <= 1'b1;
      end
    end
  end

  assign rsp_err = rsp_err_reg;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign core_start = core_start_reg;
  assign core_data  = core_data_reg;
  assign rsp_valid  = (state_reg == RESP);
  assign rsp_data   = rsp_data_reg;
  assign rsp_id     = id_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Scoreboard bench for aes_req_arbiter with a behavioural 2-cycle core model.
// Define AES_ARB_WATCHDOG_EN for both files to add the timeout scenario.
module tb_aes_req_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TMO     = 16;
  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_FIPS = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [127:0]    data;
    logic            err;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ*128-1:0] req_data = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   core_start;
  logic [127:0]           core_data;
  logic                   core_valid;
  logic [127:0]           core_result;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b1;
  logic [127:0]           rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   rsp_err;
  logic                   busy;

  logic                   model_valid = 1'b0;
  logic [127:0]           model_res = '0;
  logic                   inj_valid = 1'b0;
  logic                   core_mute = 1'b0;
  int                     pend = 0;
  logic [127:0]           pend_pt = '0;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // Ciphertexts the core model returns for each requester's block ({32{i+1}} -> its inverse).
  logic [127:0] req_pt [NUM_REQ] = '{{32{4'h1}}, {32{4'h2}}, {32{4'h3}}, {32{4'h4}}};
  logic [127:0] req_ct [NUM_REQ] = '{{32{4'hE}}, {32{4'hD}}, {32{4'hC}}, {32{4'hB}}};

  assign core_valid  = model_valid | inj_valid;
  assign core_result = model_res;

  aes_req_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .core_start(core_start), .core_data(core_data),
    .core_valid(core_valid), .core_result(core_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Core model: result strobe two cycles after the start pulse; FIPS-197 vector, else bitwise inverse.
  always begin
    @(posedge clk);
    #1;
    model_valid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0 && !core_mute) begin
        model_valid = 1'b1;
        model_res   = (pend_pt == PT_FIPS) ? CT_FIPS : ~pend_pt;
      end
    end
    if (core_start) begin
      pend    = 2;
      pend_pt = core_data;
    end
  end

  // Monitor: every response handshake is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {rsp_id, rsp_err}, '0);
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual=rsp_valid id=%0d required=no response", rsp_id);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", 128'(rsp_id), 128'(e.id));
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", 128'(rsp_err), 128'(e.err));
        $display("rsp id=%0d data=%h err=%0d", rsp_id, rsp_data, rsp_err);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input logic [127:0] data, input logic err);
    exp_t e;
    e.id = ID_W'(id); e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_ctl"}, 128'({core_start, rsp_valid, rsp_err, busy, req_ready, rsp_id}), '0);
    chk({name, "_core_data"}, core_data, '0);
    chk({name, "_rsp_data"}, rsp_data, '0);
  endtask

  task automatic wait_grant(input string name, input logic [NUM_REQ-1:0] exp);
    int n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin
      cyc();
      @(negedge clk);
      n++;
    end
    chk(name, 128'(req_ready), 128'(exp));
    $display("grant %s req_ready=%b", name, req_ready);
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      cyc();
      n++;
    end
    chk(name, 128'(exp_q.size()), '0);
  endtask

  task automatic pulse_reset();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    #3 rst = 1'b1;
    #1 chk_reset_vals("reset");
    cyc();
    cyc();
    rst = 1'b0;

    // Single request from requester 2 with the FIPS-197 block.
    cyc();
    req_data[2*128 +: 128] = PT_FIPS;
    req_valid = 4'b0100;
    push(2, CT_FIPS, 1'b0);
    wait_grant("single_grant", 4'b0100);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("start_t1", 128'({core_start, busy}), 128'(2'b11));
    chk("core_data_t1", core_data, PT_FIPS);
    cyc();
    @(negedge clk);
    chk("start_t2", 128'(core_start), '0);
    cyc();
    @(negedge clk);
    chk("rsp_valid_t3", 128'(rsp_valid), '0);
    cyc();
    @(negedge clk);
    chk("rsp_valid_t4", 128'(rsp_valid), 128'(1));
    cyc();
    @(negedge clk);
    chk("idle_t5", 128'(busy), '0);
    wait_empty("single_drain");

    // Round robin with all requesters held high for eight transactions.
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*128 +: 128] = req_pt[i];
    for (int k = 0; k < 8; k++) push(k % 4, req_ct[k % 4], 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_grant("rr_grant", NUM_REQ'(1 << (k % 4)));
      cyc();
    end
    req_valid = '0;
    wait_empty("rr_drain");

    // Response stall: requester 1 held in RESP for 10 cycles while requester 0 waits.
    rsp_ready = 1'b0;
    push(1, req_ct[1], 1'b0);
    push(0, req_ct[0], 1'b0);
    req_valid = 4'b0010;
    wait_grant("stall_grant", 4'b0010);
    cyc();
    req_valid = 4'b0001;
    begin
      int n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 10) begin
        cyc();
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      chk("stall_ctl", 128'({rsp_valid, rsp_id, req_ready, core_start}), 128'({1'b1, 2'd1, 4'b0000, 1'b0}));
      chk("stall_data", rsp_data, req_ct[1]);
      cyc();
      @(negedge clk);
    end
    cyc();
    rsp_ready = 1'b1;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("post_stall_idle", 128'({busy, req_ready}), 128'({1'b0, 4'b0001}));
    cyc();
    req_valid = '0;
    wait_empty("stall_drain");

    // Reset while in WAIT_CORE; the core's late strobe must be ignored.
    req_valid = 4'b1000;
    wait_grant("abort_grant", 4'b1000);
    cyc();
    req_valid = '0;
    cyc();
    rst = 1'b1;
    #1 chk_reset_vals("abort_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      chk("abort_quiet", 128'({rsp_valid, busy}), '0);
    end
    cyc();
    push(0, req_ct[0], 1'b0);
    req_valid = 4'b1001;
    wait_grant("abort_next_grant", 4'b0001);
    cyc();
    req_valid = '0;
    wait_empty("abort_drain");

    // Stray core_valid while idle.
    cyc();
    inj_valid = 1'b1;
    @(negedge clk);
    chk("inject_idle_busy", 128'(busy), '0);
    cyc();
    inj_valid = 1'b0;
    @(negedge clk);
    chk("inject_idle_after", 128'({rsp_valid, busy}), '0);

`ifdef AES_ARB_WATCHDOG_EN
    // Watchdog: silent core, abort response TMO cycles after WAIT_CORE entry.
    cyc();
    core_mute = 1'b1;
    rsp_ready = 1'b0;
    push(2, '0, 1'b1);
    req_valid = 4'b0100;
    wait_grant("wd_grant", 4'b0100);
    repeat (TMO + 1) begin
      cyc();
      req_valid = '0;
    end
    @(negedge clk);
    chk("wd_before", 128'(rsp_valid), '0);
    cyc();
    @(negedge clk);
    chk("wd_fire", 128'({rsp_valid, rsp_err}), 128'(2'b11));
    cyc();
    rsp_ready = 1'b1;
    wait_empty("wd_drain");
    core_mute = 1'b0;
    cyc();
    inj_valid = 1'b1;
    cyc();
    inj_valid = 1'b0;
    @(negedge clk);
    chk("wd_stray", 128'({rsp_valid, busy}), '0);
`endif

    cyc();
    chk("final_queue", 128'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_req_arbiter.md
# aes_req_arbiter

Round-robin scheduler that shares one AES-256 encrypt core (14-round, 2-cycle start-to-valid handshake) among NUM_REQ requesters. Each requester hands over a 128-bit plaintext block with a valid/ready handshake. The arbiter sequences the core's start/valid protocol and holds the core input stable for the whole operation. It returns the ciphertext tagged with the requester ID on a back-pressurable response port. Round keys go to the core directly and do not pass through this block.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, $clog2(NUM_REQ): width of the requester ID.
- TIMEOUT_CYCLES, 16: core watchdog limit; used only when the watchdog is compiled in.

- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  one clock; reset is asynchronous and active-high.
- req_valid  in  NUM_REQ  per-requester block offered.
- req_data  in  NUM_REQ*128  plaintext; requester i uses bits [128*i +: 128].
- req_ready  out  NUM_REQ  one-hot accept strobe; combinational.
- core_start  out  1  registered one-cycle start pulse to the core (core `ready`).
- core_data  out  128  registered plaintext to the core, held until core_valid.
- core_valid  in  1  core result strobe.
- core_result  in  128  core ciphertext, sampled only when core_valid=1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer accepts.
- rsp_data  out  128  ciphertext.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_err  out  1  response is a watchdog abort; rsp_data=0 when set.
- busy  out  1  high whenever the FSM state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT_CORE, RESP. One transaction is in flight at a time.
- **IDLE:**
  - If any req_valid is high, grant the first set bit searching upward from last_grant+1 (mod NUM_REQ).
  - In the same cycle: req_ready[g]=1, core_data<=req_data[g], id<=g, last_grant<=g, then go to ISSUE.
  - If no req_valid is high, req_ready is all-zero.
- **ISSUE:** core_start=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT_CORE.
- **WAIT_CORE:** hold core_data. On core_valid, set rsp_data<=core_result and rsp_err<=0, then go to RESP.
- **RESP:**
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are stable.
  - When rsp_ready=1, complete the handshake and go to IDLE.
  - If rsp_ready=0, hold indefinitely.
- req_ready is zero in every state except IDLE, so a requester may hold req_valid across the entire transaction of another requester.
- A core_valid that arrives outside WAIT_CORE is ignored.
- Reset values: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), core_start=0, core_data=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, req_ready=0.
- Reset mid-transaction aborts the transaction. The accepted block is lost and no response is produced. A core_valid that arrives after reset is ignored by the rule above.

## Timing
- Request accepted in cycle T, then core_start in T+1. With the standard core, core_valid arrives in T+3 and rsp_valid in T+4.
- In general, rsp_valid rises on the cycle after core_valid.
- Minimum acceptance-to-acceptance spacing is 5 cycles: rsp_ready in T+4, back in IDLE in T+5, next grant in T+5.
- rsp_ready at RESP and a new req_valid in the same cycle: the new grant happens the following cycle. RESP never grants.
- Round-robin fairness: a requester that holds req_valid continuously waits at most NUM_REQ-1 transactions.

## Configuration
- AES_ARB_WATCHDOG_EN defined:
  - A counter runs in WAIT_CORE.
  - If the counter reaches TIMEOUT_CYCLES with no core_valid, go to RESP with rsp_data=0, rsp_err=1 and rsp_id=granted ID.
  - Any later stray core_valid is ignored.
- AES_ARB_WATCHDOG_EN undefined:
  - There is no counter. WAIT_CORE waits indefinitely.
  - rsp_err is tied to 0. TIMEOUT_CYCLES is unused.

## Test plan
- After reset, only req_valid[2]=1 with data 0x00112233445566778899aabbccddeeff: req_ready=4'b0100 in T, core_start in T+1, rsp_valid in T+4 with rsp_id=2 and rsp_data equal to the core's FIPS-197 ciphertext.
- All four req_valid held high for 8 transactions with rsp_ready=1: rsp_id sequence is 0,1,2,3,0,1,2,3.
- rsp_ready held 0 for 10 cycles during RESP: rsp_valid, rsp_data and rsp_id stay constant, req_ready stays 0, core_start does not fire again. Release the stall: IDLE one cycle later.
- Assert rst during WAIT_CORE: all outputs return to their reset values immediately. The next core_valid produces no rsp_valid. Next grant goes to requester 0.
- Watchdog enabled, core model suppresses core_valid: rsp_valid=1 with rsp_err=1 and rsp_data=0 exactly TIMEOUT_CYCLES cycles after WAIT_CORE entry. A later core_valid is ignored.
- Inject core_valid in IDLE: no state change and no rsp_valid.
